// File: rtl/paralelo_serial_tx_if.sv
// ============================================================================
// Module      : paralelo_serial_tx_if
// Description : Byte handshake and serial-side signals of the PHY transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface paralelo_serial_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             valid_in;
  logic             ready;
  logic             data_out;
  logic             active;
  logic             symbol_start;

  modport master (
    output data_in, valid_in,
    input  ready, data_out, active, symbol_start
  );

  modport slave (
    input  data_in, valid_in,
    output ready, data_out, active, symbol_start
  );
endinterface

`default_nettype wire

// File: rtl/paralelo_serial_tx.sv
// ============================================================================
// Module      : paralelo_serial_tx
// Description : Parallel-to-serial PHY transmitter: comma sync, then MSB-first
//               bytes from a one-entry holding register, COM fill when idle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module paralelo_serial_tx #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] COM_SYMBOL = 8'hBC,
  parameter int               SYNC_COUNT = 4
) (
  input  wire logic              clk_32f,
  input  wire logic              reset,
  paralelo_serial_tx_if.slave    bus
);

  localparam int              c_CW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_CW-1:0] c_BIT_TOP   = c_CW'(WIDTH - 1);
  localparam logic [3:0]      c_SYNC_LAST = 4'(SYNC_COUNT - 1);
  localparam logic [3:0]      c_SYNC_MAX  = 4'(SYNC_COUNT);

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_SYNC  = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [WIDTH-1:0]  r_shift, w_shift_nxt;
  logic [WIDTH-1:0]  r_hold, w_hold_nxt;
  logic              r_hold_full, w_hold_full_nxt;
  logic [c_CW-1:0]   r_bit_cnt, w_bit_cnt_nxt;
  logic [3:0]        r_sync_cnt, w_sync_cnt_nxt;
  logic              r_active, w_active_nxt;
  logic              r_ready, w_ready_nxt;
  logic              r_sym_start, w_sym_start_nxt;
  logic [WIDTH-1:0]  w_sym;
  logic              w_load;
  logic              w_accept;

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      r_state     <= ST_RESET;
      r_shift     <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_bit_cnt   <= c_BIT_TOP;
      r_sync_cnt  <= '0;
      r_active    <= 1'b0;
      r_ready     <= 1'b0;
      r_sym_start <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_shift     <= w_shift_nxt;
      r_hold      <= w_hold_nxt;
      r_hold_full <= w_hold_full_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_sync_cnt  <= w_sync_cnt_nxt;
      r_active    <= w_active_nxt;
      r_ready     <= w_ready_nxt;
      r_sym_start <= w_sym_start_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_sync_cnt_nxt  = r_sync_cnt;
    w_active_nxt    = r_active;
    w_hold_nxt      = r_hold;
    w_hold_full_nxt = r_hold_full;
    w_sym           = COM_SYMBOL;
    // The first edge out of reset is a load edge so symbols start immediately.
    w_load          = (r_state == ST_RESET) || (r_bit_cnt == '0);
    w_accept        = bus.valid_in && r_ready;

    if (w_load && (r_state == ST_RUN) && r_hold_full) begin
      w_sym           = r_hold;
      w_hold_full_nxt = 1'b0;
    end
    // Accepted bytes only ever land in the holding register.
    if (w_accept) begin
      w_hold_nxt      = bus.data_in;
      w_hold_full_nxt = 1'b1;
    end

    if (w_load) begin
      w_shift_nxt     = w_sym;
      w_bit_cnt_nxt   = c_BIT_TOP;
      w_sym_start_nxt = 1'b1;
    end else begin
      w_shift_nxt     = {r_shift[WIDTH-2:0], 1'b0};
      w_bit_cnt_nxt   = r_bit_cnt - c_CW'(1);
      w_sym_start_nxt = 1'b0;
    end

    case (r_state)
      ST_RESET: w_state_nxt = ST_SYNC;
      ST_SYNC: begin
        if (w_load) begin
          if (r_sync_cnt < c_SYNC_MAX) begin
            w_sync_cnt_nxt = r_sync_cnt + 4'd1;
          end
          if (r_sync_cnt == c_SYNC_LAST) begin
            w_state_nxt  = ST_RUN;
            w_active_nxt = 1'b1;
          end
        end
      end
      ST_RUN:  w_active_nxt = 1'b1;
      default: w_state_nxt  = ST_RESET;
    endcase

    w_ready_nxt = w_active_nxt && !w_hold_full_nxt;
  end

  assign bus.data_out     = r_shift[WIDTH-1];
  assign bus.ready        = r_ready;
  assign bus.active       = r_active;
  assign bus.symbol_start = r_sym_start;

endmodule

`default_nettype wire
